riscv_run_ctrl: RTL

RISCV_RUN_CTRL -- requirements
Module: riscv_run_ctrl

---
 rtl/riscv_pkg.sv | 35 +++
 rtl/riscv_sig_accum.sv | 42 ++++
 rtl/riscv_run_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the run controller.
//   run_state_e : run-controller FSM states
//   rotl        : rotate-left helper. The width is passed as an argument so one
//                 function can serve any XLEN up to MaxXlen.
package riscv_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StResetHold = 3'd1,
    StRun       = 3'd2,
    StDone      = 3'd3,
    StTimeout   = 3'd4
  } run_state_e;

  localparam int unsigned MaxXlen = 128;
  localparam int unsigned IdxW    = $clog2(MaxXlen);

  // Rotate the low 'width' bits of value left by 'amount'; the upper bits of
  // the result are zero.
  function automatic logic [MaxXlen-1:0] rotl(input logic [MaxXlen-1:0] value,
                                              input int unsigned width,
                                              input int unsigned amount);
    logic [MaxXlen-1:0] rot;
    logic [IdxW-1:0]    idx;
    rot = '0;
    for (int unsigned i = 0; i < MaxXlen; i++) begin
      if (i < width) begin
        idx      = IdxW'((i + amount) % width);
        rot[idx] = value[IdxW'(i)];
      end
    end
    return rot;
  endfunction

endpackage

// File: rtl/riscv_sig_accum.sv
// Result signature accumulator: sig <= rotl(sig, 1) ^ data on each enabled cycle.
// Ports:
//   clk, reset (async, active-low)
//   clear  : synchronous clear to zero; takes priority over enable
//   enable : accumulate data this cycle
//   data   : XLEN-bit value to fold in
//   sig    : registered signature
module riscv_sig_accum
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] sig
);

  logic [XLEN-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clear) begin
      sig_d = '0;
    end else if (enable) begin
      sig_d = XLEN'(rotl(MaxXlen'(sig_q), XLEN, 1)) ^ data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/riscv_run_ctrl.sv
// Run controller for a core under test: holds the core in reset after start,
// lets it run, accumulates a signature of its valid results and ends the run
// on halt (DONE) or after TIMEOUT_CYCLES RUN cycles (TIMEOUT).
// Optional feature macro: RISCV_RUN_CTRL_EXPECT_EN adds expected_sig / pass.
// Ports:
//   clk, reset (async, active-low)
//   start                : begin a new run (ignored while busy)
//   halt                 : core reports end of program
//   result_valid, result : core result stream
//   expected_sig, pass   : (EXPECT_EN only) signature compare in DONE
//   core_reset           : active-high reset to the core
//   busy, done, timeout  : run status
//   signature            : accumulated result signature
//   cycle_count          : RUN cycles elapsed
//   result_count         : valid results accumulated
module riscv_run_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN            = 64,
  parameter int unsigned RST_HOLD_CYCLES = 1,
  parameter int unsigned TIMEOUT_CYCLES  = 100,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  input  logic             result_valid,
  input  logic [XLEN-1:0]  result,
`ifdef RISCV_RUN_CTRL_EXPECT_EN
  input  logic [XLEN-1:0]  expected_sig,
  output logic             pass,
`endif
  output logic             core_reset,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [XLEN-1:0]  signature,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] result_count
);

  run_state_e       state_q;
  logic [7:0]       hold_cnt_q;
  logic [CNT_W-1:0] cycle_cnt_q, result_cnt_q;
  logic             core_reset_q, busy_q, done_q, timeout_q;

  logic in_run, accept_start, hold_last, timeout_hit;

  assign in_run       = (state_q == StRun);
  assign accept_start = start && (state_q inside {StIdle, StDone, StTimeout});
  assign hold_last    = (hold_cnt_q == 8'(RST_HOLD_CYCLES - 1));
  assign timeout_hit  = (cycle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      hold_cnt_q   <= '0;
      cycle_cnt_q  <= '0;
      result_cnt_q <= '0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone, StTimeout: begin
          if (start) begin
            state_q      <= StResetHold;
            hold_cnt_q   <= '0;
            cycle_cnt_q  <= '0;
            result_cnt_q <= '0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
          end
        end
        StResetHold: begin
          if (hold_last) begin
            state_q      <= StRun;
            core_reset_q <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
        StRun: begin
          // A result presented together with halt is still counted.
          if (result_valid && (result_cnt_q != '1)) begin
            result_cnt_q <= result_cnt_q + 1'b1;
          end
          // cycle_count freezes on the edge that leaves RUN, so a timeout
          // reports TIMEOUT_CYCLES-1.
          if (halt) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (timeout_hit) begin
            state_q   <= StTimeout;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else if (cycle_cnt_q != '1) begin
            cycle_cnt_q <= cycle_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q      <= StIdle;
          core_reset_q <= 1'b1;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
          timeout_q    <= 1'b0;
        end
      endcase
    end
  end

  riscv_sig_accum #(
    .XLEN(XLEN)
  ) u_sig_accum (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept_start),
    .enable (in_run && result_valid),
    .data   (result),
    .sig    (signature)
  );

`ifdef RISCV_RUN_CTRL_EXPECT_EN
  logic pass_q;

  // Registered so expected_sig has no combinational path to pass; a start in
  // DONE drops pass on the same edge that leaves DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass_q <= 1'b0;
    end else begin
      pass_q <= (state_q == StDone) && !start && (signature == expected_sig);
    end
  end

  assign pass = pass_q;
`endif

  assign core_reset   = core_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign cycle_count  = cycle_cnt_q;
  assign result_count = result_cnt_q;

endmodule
